// File: rtl/bsg_manycore_pkg.sv
// Shared definitions for the manycore link credit bridge.
// Error bit positions and credit-counter sizing.
package bsg_manycore_pkg;

  localparam int e_credit_bridge_err_ovf_ingress = 0;
  localparam int e_credit_bridge_err_ovf_credit  = 1;
  localparam int credit_bridge_err_width         = 2;

  function automatic int credit_cnt_width(input int max_credits);
    return $clog2(max_credits + 1);
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read one-write FIFO with valid/yumi dequeue.
// Register-array storage with an occupancy counter.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 64,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] wptr_r, rptr_r;
  logic [cnt_w_lp-1:0] cnt_r;
  logic                enq, deq;

  function automatic logic [ptr_w_lp-1:0] bump(
    input logic [ptr_w_lp-1:0] p
  );
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  // a full FIFO still accepts when the head leaves this cycle
  assign ready_o = (cnt_r != cnt_w_lp'(els_p)) | yumi_i;
  assign v_o     = (cnt_r != '0);
  assign data_o  = mem_r[rptr_r];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r] <= data_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cnt_r  <= '0;
    end else begin
      if (enq) wptr_r <= bump(wptr_r);
      if (deq) rptr_r <= bump(rptr_r);
      unique case (1'b1)
        enq & ~deq: cnt_r <= cnt_r + cnt_w_lp'(1);
        deq & ~enq: cnt_r <= cnt_r - cnt_w_lp'(1);
        default:    cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/bsg_manycore_link_credit_bridge_channel.sv
// One channel of the credit bridge: ingress FIFO with credit
// return, egress credit counter, idle and sticky error flags.
module bsg_manycore_link_credit_bridge_channel
  import bsg_manycore_pkg::*;
#(
  parameter int width_p           = 64,
  parameter int fifo_els_p        = 4,
  parameter int max_out_credits_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic               cin_v_i,
  input  logic [width_p-1:0] cin_data_i,
  output logic               cin_credit_o,
  output logic               rout_v_o,
  output logic [width_p-1:0] rout_data_o,
  input  logic               rout_ready_and_i,
  input  logic               rin_v_i,
  input  logic [width_p-1:0] rin_data_i,
  output logic               rin_ready_and_o,
  output logic               cout_v_o,
  output logic [width_p-1:0] cout_data_o,
  input  logic               cout_credit_i,
  output logic               idle_o,
  output logic [credit_bridge_err_width-1:0] err_o
);

  localparam int cnt_w_lp = credit_cnt_width(max_out_credits_p);
  localparam logic [cnt_w_lp-1:0] cnt_max_lp =
    cnt_w_lp'(max_out_credits_p);

  logic                fifo_ready, fifo_v;
  logic                deq, send, ovf_in, ovf_cr;
  logic [cnt_w_lp-1:0] cnt_r;
  logic                credit_r;
  logic [credit_bridge_err_width-1:0] err_r;

  bsg_fifo_1r1w_small #(
    .width_p(width_p),
    .els_p  (fifo_els_p)
  ) fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (cin_v_i),
    .ready_o(fifo_ready),
    .data_i (cin_data_i),
    .v_o    (fifo_v),
    .data_o (rout_data_o),
    .yumi_i (deq)
  );

  assign rout_v_o        = fifo_v & enable_i;
  assign deq             = rout_v_o & rout_ready_and_i;
  assign ovf_in          = cin_v_i & ~fifo_ready;
  assign rin_ready_and_o = enable_i & (cnt_r != '0);
  assign send            = rin_v_i & rin_ready_and_o;
  assign cout_v_o        = send;
  assign cout_data_o     = rin_data_i;
  assign ovf_cr          = cout_credit_i & ~send
                         & (cnt_r == cnt_max_lp);
  assign cin_credit_o    = credit_r;
  assign idle_o          = ~fifo_v & ~credit_r
                         & (cnt_r == cnt_max_lp);
  assign err_o           = err_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_r    <= cnt_max_lp;
      credit_r <= 1'b0;
      err_r    <= '0;
    end else begin
      credit_r <= deq;
      if (ovf_in) err_r[e_credit_bridge_err_ovf_ingress] <= 1'b1;
      if (ovf_cr) err_r[e_credit_bridge_err_ovf_credit]  <= 1'b1;
      unique case (1'b1)
        send & ~cout_credit_i:
          cnt_r <= cnt_r - cnt_w_lp'(1);
        cout_credit_i & ~send & (cnt_r != cnt_max_lp):
          cnt_r <= cnt_r + cnt_w_lp'(1);
        default:
          cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/bsg_manycore_link_credit_bridge.sv
// Multi-channel credit <-> ready_and link bridge.
// Independent channels over flat packed port arrays.
module bsg_manycore_link_credit_bridge
  import bsg_manycore_pkg::*;
#(
  parameter int width_p           = 64,
  parameter int channels_p        = 2,
  parameter int fifo_els_p        = 4,
  parameter int max_out_credits_p = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [channels_p-1:0]         enable_i,
  input  logic [channels_p-1:0]         cin_v_i,
  input  logic [channels_p*width_p-1:0] cin_data_i,
  output logic [channels_p-1:0]         cin_credit_o,
  output logic [channels_p-1:0]         rout_v_o,
  output logic [channels_p*width_p-1:0] rout_data_o,
  input  logic [channels_p-1:0]         rout_ready_and_i,
  input  logic [channels_p-1:0]         rin_v_i,
  input  logic [channels_p*width_p-1:0] rin_data_i,
  output logic [channels_p-1:0]         rin_ready_and_o,
  output logic [channels_p-1:0]         cout_v_o,
  output logic [channels_p*width_p-1:0] cout_data_o,
  input  logic [channels_p-1:0]         cout_credit_i,
  output logic [channels_p-1:0]         idle_o,
  output logic [channels_p*credit_bridge_err_width-1:0] err_o
);

  localparam int ew_lp = credit_bridge_err_width;

  for (genvar ch = 0; ch < channels_p; ch++) begin : g_ch
    bsg_manycore_link_credit_bridge_channel #(
      .width_p          (width_p),
      .fifo_els_p       (fifo_els_p),
      .max_out_credits_p(max_out_credits_p)
    ) chan (
      .clk_i           (clk_i),
      .reset_i         (reset_i),
      .enable_i        (enable_i[ch]),
      .cin_v_i         (cin_v_i[ch]),
      .cin_data_i      (cin_data_i[ch*width_p +: width_p]),
      .cin_credit_o    (cin_credit_o[ch]),
      .rout_v_o        (rout_v_o[ch]),
      .rout_data_o     (rout_data_o[ch*width_p +: width_p]),
      .rout_ready_and_i(rout_ready_and_i[ch]),
      .rin_v_i         (rin_v_i[ch]),
      .rin_data_i      (rin_data_i[ch*width_p +: width_p]),
      .rin_ready_and_o (rin_ready_and_o[ch]),
      .cout_v_o        (cout_v_o[ch]),
      .cout_data_o     (cout_data_o[ch*width_p +: width_p]),
      .cout_credit_i   (cout_credit_i[ch]),
      .idle_o          (idle_o[ch]),
      .err_o           (err_o[ch*ew_lp +: ew_lp])
    );
  end

endmodule

// File: tb/tb_bsg_manycore_link_credit_bridge.sv
// Bench for the credit bridge: queue-based reference model
// with directed scenarios and randomized traffic.
module tb_bsg_manycore_link_credit_bridge;

  localparam int W    = 64;
  localparam int NCH  = 2;
  localparam int ELS  = 4;
  localparam int MAXC = 4;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic [NCH-1:0]   enable_i, cin_v_i, cin_credit_o;
  logic [NCH-1:0]   rout_v_o, rout_ready_and_i;
  logic [NCH-1:0]   rin_v_i, rin_ready_and_o;
  logic [NCH-1:0]   cout_v_o, cout_credit_i, idle_o;
  logic [NCH*W-1:0] cin_data_i, rout_data_o;
  logic [NCH*W-1:0] rin_data_i, cout_data_o;
  logic [NCH*2-1:0] err_o;

  always #5 clk_i = ~clk_i;

  bsg_manycore_link_credit_bridge #(
    .width_p(W), .channels_p(NCH),
    .fifo_els_p(ELS), .max_out_credits_p(MAXC)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .enable_i(enable_i),
    .cin_v_i(cin_v_i), .cin_data_i(cin_data_i),
    .cin_credit_o(cin_credit_o),
    .rout_v_o(rout_v_o), .rout_data_o(rout_data_o),
    .rout_ready_and_i(rout_ready_and_i),
    .rin_v_i(rin_v_i), .rin_data_i(rin_data_i),
    .rin_ready_and_o(rin_ready_and_o),
    .cout_v_o(cout_v_o), .cout_data_o(cout_data_o),
    .cout_credit_i(cout_credit_i),
    .idle_o(idle_o), .err_o(err_o)
  );

  // reference model: packet queue, credit count, pending return
  logic [W-1:0] mq [NCH][$];
  int           mcnt  [NCH];
  bit           mpend [NCH];
  bit           merr0 [NCH];
  bit           merr1 [NCH];

  int checks   = 0;
  int failures = 0;

  task automatic chk(string name, int ch,
                     logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s ch%0d got=%0h want=%0h t=%0t",
                 name, ch, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      mcnt[c]  = MAXC;
      mpend[c] = 1'b0;
      merr0[c] = 1'b0;
      merr1[c] = 1'b0;
    end
  endtask

  // compare all outputs, advance model, return at next negedge
  task automatic tick();
    #1;
    for (int c = 0; c < NCH; c++) begin
      bit en, e_rv, e_rr, e_cv, deq;
      en   = enable_i[c];
      e_rv = en && (mq[c].size() > 0);
      e_rr = en && (mcnt[c] > 0);
      e_cv = rin_v_i[c] && e_rr;
      chk("rout_v", c, rout_v_o[c], e_rv);
      if (e_rv)
        chk("rout_data", c, rout_data_o[c*W +: W], mq[c][0]);
      chk("cin_credit", c, cin_credit_o[c], mpend[c]);
      chk("rin_ready", c, rin_ready_and_o[c], e_rr);
      chk("cout_v", c, cout_v_o[c], e_cv);
      if (e_cv)
        chk("cout_data", c, cout_data_o[c*W +: W],
            rin_data_i[c*W +: W]);
      chk("idle", c, idle_o[c], (mq[c].size() == 0)
          && (mcnt[c] == MAXC) && !mpend[c]);
      chk("err", c, err_o[c*2 +: 2], {merr1[c], merr0[c]});
      deq = e_rv && rout_ready_and_i[c];
      if (deq) void'(mq[c].pop_front());
      if (cin_v_i[c]) begin
        if (mq[c].size() < ELS)
          mq[c].push_back(cin_data_i[c*W +: W]);
        else
          merr0[c] = 1'b1;
      end
      mpend[c] = deq;
      if (e_cv && !cout_credit_i[c]) mcnt[c]--;
      else if (cout_credit_i[c] && !e_cv) begin
        if (mcnt[c] == MAXC) merr1[c] = 1'b1;
        else mcnt[c]++;
      end
    end
    @(negedge clk_i);
  endtask

  task automatic quiet();
    enable_i         = '1;
    cin_v_i          = '0;
    cin_data_i       = '0;
    rout_ready_and_i = '0;
    rin_v_i          = '0;
    rin_data_i       = '0;
    cout_credit_i    = '0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    #1;
    for (int c = 0; c < NCH; c++) begin
      chk("rst_rout_v", c, rout_v_o[c], 0);
      chk("rst_credit", c, cin_credit_o[c], 0);
      chk("rst_idle", c, idle_o[c], 1);
      chk("rst_err", c, err_o[c*2 +: 2], 0);
      chk("rst_rin_ready", c, rin_ready_and_o[c], enable_i[c]);
    end
    model_reset();
    @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  task automatic rand_inputs();
    for (int c = 0; c < NCH; c++) begin
      enable_i[c]         = ($urandom % 10) != 0;
      cin_v_i[c]          = ($urandom % 3) == 0;
      cin_data_i[c*W +: W] = {$urandom, $urandom};
      rout_ready_and_i[c] = $urandom % 2;
      rin_v_i[c]          = $urandom % 2;
      rin_data_i[c*W +: W] = {$urandom, $urandom};
      cout_credit_i[c]    = ((mcnt[c] < MAXC) && ($urandom % 3 == 0))
                          || ($urandom % 97 == 0);
    end
  endtask

  logic [W-1:0] got [8];
  int n, cr, first_idle;

  initial begin
    quiet();
    do_reset();

    // 1: fill FIFO with no ready, then drain in order
    for (int i = 0; i < 4; i++) begin
      cin_v_i[0] = 1'b1;
      cin_data_i[0 +: W] = 64'hA000_0000_0000_0000 + 64'(i);
      tick();
    end
    cin_v_i = '0;
    #1;
    chk("t1_full_rv", 0, rout_v_o[0], 1);
    chk("t1_no_credit", 0, cin_credit_o[0], 0);
    chk("t1_head", 0, rout_data_o[0 +: W], 64'hA000_0000_0000_0000);
    chk("t1_model_depth", 0, mq[0].size(), 4);
    rout_ready_and_i[0] = 1'b1;
    n = 0; cr = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (rout_v_o[0]) begin
        got[n] = rout_data_o[0 +: W];
        n++;
      end
      if (cin_credit_o[0]) cr++;
      tick();
    end
    chk("t1_npkts", 0, n, 4);
    chk("t1_ncredits", 0, cr, 4);
    for (int i = 0; i < 4; i++)
      chk("t1_order", 0, got[i], 64'hA000_0000_0000_0000 + 64'(i));

    // 4: ingress overflow and credit overflow
    quiet();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cin_v_i[0] = 1'b1;
      cin_data_i[0 +: W] = 64'hB000_0000_0000_0000 + 64'(i);
      tick();
    end
    cin_v_i = '0;
    #1;
    chk("t4_err_in", 0, err_o[1:0], 2'b01);
    chk("t4_model_depth", 0, mq[0].size(), 4);
    cout_credit_i[0] = 1'b1;
    tick();
    cout_credit_i[0] = 1'b0;
    #1;
    chk("t4_err_both", 0, err_o[1:0], 2'b11);
    chk("t4_cnt_max", 0, mcnt[0], MAXC);
    rout_ready_and_i[0] = 1'b1;
    #1;
    chk("t4_head", 0, rout_data_o[0 +: W], 64'hB000_0000_0000_0000);
    for (int k = 0; k < 6; k++) tick();
    #1;
    chk("t4_sticky", 0, err_o[1:0], 2'b11);

    // 2/3: credit exhaustion and replenish
    quiet();
    do_reset();
    rin_v_i[0] = 1'b1;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      rin_data_i[0 +: W] = 64'hC000_0000_0000_0000 + 64'(k);
      #1;
      if (cout_v_o[0]) n++;
      tick();
    end
    chk("t2_sends", 0, n, 4);
    #1;
    chk("t2_stall", 0, rin_ready_and_o[0], 0);
    cout_credit_i[0] = 1'b1;
    tick();
    cout_credit_i[0] = 1'b0;
    #1;
    chk("t3_reopen", 0, rin_ready_and_o[0], 1);
    n = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (cout_v_o[0]) n++;
      tick();
    end
    chk("t2_one_more", 0, n, 1);

    quiet();
    do_reset();
    rin_v_i[0] = 1'b1;
    tick();
    tick();
    cout_credit_i[0] = 1'b1;
    tick();
    cout_credit_i[0] = 1'b0;
    chk("t3_model_cnt", 0, mcnt[0], 2);
    n = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (cout_v_o[0]) n++;
      tick();
    end
    chk("t3_cnt_kept", 0, n, 2);

    // 5: quiesce with buffered packets, then drain
    quiet();
    do_reset();
    enable_i[0] = 1'b0;
    rout_ready_and_i[0] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cin_v_i[0] = 1'b1;
      cin_data_i[0 +: W] = 64'hD000_0000_0000_0000 + 64'(i);
      tick();
    end
    cin_v_i = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t5_rv_off", 0, rout_v_o[0], 0);
      chk("t5_busy", 0, idle_o[0], 0);
      tick();
    end
    enable_i[0] = 1'b1;
    first_idle = -1;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (idle_o[0] && first_idle < 0) first_idle = k;
      tick();
    end
    chk("t5_idle_cycle", 0, first_idle, 3);

    // 6: reset mid-burst while channel 1 streams
    quiet();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      rand_inputs();
      enable_i = '1;
      cin_v_i[0] = 1'b1;
      rout_ready_and_i[0] = 1'b1;
      tick();
    end
    #2;
    do_reset();
    for (int k = 0; k < 30; k++) begin
      rand_inputs();
      tick();
    end

    // randomized segments separated by resets
    for (int s = 0; s < 4; s++) begin
      quiet();
      do_reset();
      for (int k = 0; k < 500; k++) begin
        rand_inputs();
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
